// File: rtl/sdram_port_bist.sv
// sdram_port_bist: write/read-back traffic generator and checker for one
// SDRAM controller client port (p0 handshake). Writes NUM_WORDS words from
// base_addr with a generated pattern, reads them back, and reports the
// mismatch count, the first failing word and any handshake timeout.
module sdram_port_bist #(
  parameter int ADDR_WIDTH     = 21,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_WORDS      = 8,
  parameter int PATTERN_MODE   = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERR_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    init_complete,
  output logic [ADDR_WIDTH-1:0]   p0_addr,
  output logic [DATA_WIDTH-1:0]   p0_data,
  output logic [DATA_WIDTH/8-1:0] p0_byte_en,
  output logic                    p0_wr_req,
  output logic                    p0_rd_req,
  input  logic                    p0_ready,
  input  logic [DATA_WIDTH-1:0]   p0_q,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ERR_WIDTH-1:0]    error_count,
  output logic [ADDR_WIDTH-1:0]   first_err_addr,
  output logic [DATA_WIDTH-1:0]   first_err_exp,
  output logic [DATA_WIDTH-1:0]   first_err_got
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] LFSR_SEED = 32'h0000_ACE1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_INIT,
    S_WR_ISSUE, S_WR_WAIT_LO, S_WR_WAIT_HI,
    S_RD_ISSUE, S_RD_WAIT_LO, S_RD_WAIT_HI,
    S_FINISH
  } state_t;

  // Right-shifting Galois LFSR: shift out bit 0, fold taps back in when it was 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // Data pattern for one word; the LFSR value is replicated/truncated to width.
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic [31:0]           l,
                                                    input logic [IDX_W-1:0]      i);
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    case (PATTERN_MODE)
      0:       r = DATA_WIDTH'(a);
      1:       for (int b = 0; b < DATA_WIDTH; b++) r[b] = l[b % 32];
      default: for (int b = 0; b < DATA_WIDTH; b++) r[b] = (b == (int'(i) % DATA_WIDTH));
    endcase
    return r;
  endfunction

  state_t                 state_q;
  logic [ADDR_WIDTH-1:0]  base_q, addr_q, fea_q;
  logic [DATA_WIDTH-1:0]  data_q, fee_q, feg_q;
  logic [BE_W-1:0]        be_q;
  logic                   wr_q, rd_q, busy_q, done_q, pass_q, to_q;
  logic [IDX_W-1:0]       idx_q;
  logic [31:0]            lfsr_q;
  logic [WCNT_W-1:0]      wcnt_q;
  logic [ERR_WIDTH-1:0]   err_q;

  logic                   wait_st, wait_met, to_hit, last;
  logic [DATA_WIDTH-1:0]  cur_pat, nxt_pat_d;
  logic [ADDR_WIDTH-1:0]  nxt_addr_d;
  logic [IDX_W-1:0]       nxt_idx_d;
  logic [31:0]            nxt_lfsr_d;

  // Wait-state qualifiers and the current/next word's address and pattern.
  always_comb begin
    wait_st    = (state_q == S_WR_WAIT_LO) || (state_q == S_WR_WAIT_HI) ||
                 (state_q == S_RD_WAIT_LO) || (state_q == S_RD_WAIT_HI);
    wait_met   = ((state_q == S_WR_WAIT_LO) || (state_q == S_RD_WAIT_LO)) ? !p0_ready : p0_ready;
    to_hit     = (wcnt_q == WCNT_W'(TIMEOUT_CYCLES - 1));
    last       = (idx_q == IDX_W'(NUM_WORDS - 1));
    cur_pat    = pattern(addr_q, lfsr_q, idx_q);
    nxt_addr_d = addr_q + ADDR_WIDTH'(1);
    nxt_idx_d  = idx_q + IDX_W'(1);
    nxt_lfsr_d = lfsr_step(lfsr_q);
    nxt_pat_d  = pattern(nxt_addr_d, nxt_lfsr_d, nxt_idx_d);
  end

  // Run sequencer; request outputs are registered and set on entry to the issue states.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= '0;
      fea_q   <= '0;
      fee_q   <= '0;
      feg_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          base_q  <= base_addr;
          addr_q  <= base_addr;
          idx_q   <= '0;
          lfsr_q  <= LFSR_SEED;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
          to_q    <= 1'b0;
          err_q   <= '0;
          fea_q   <= '0;
          fee_q   <= '0;
          feg_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_WAIT_INIT;
        end
        S_WAIT_INIT: if (init_complete && p0_ready) begin
          wr_q    <= 1'b1;
          be_q    <= '1;
          data_q  <= cur_pat;
          state_q <= S_WR_ISSUE;
        end
        S_WR_ISSUE: begin
          wr_q    <= 1'b0;
          wcnt_q  <= '0;
          state_q <= S_WR_WAIT_LO;
        end
        S_WR_WAIT_LO: if (wait_met) begin
          wcnt_q  <= '0;
          state_q <= S_WR_WAIT_HI;
        end
        S_WR_WAIT_HI: if (wait_met) begin
          if (last) begin
            // Rewind and reseed so the read pass regenerates the written sequence.
            idx_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            addr_q  <= base_q;
            rd_q    <= 1'b1;
            state_q <= S_RD_ISSUE;
          end else begin
            idx_q   <= nxt_idx_d;
            lfsr_q  <= nxt_lfsr_d;
            addr_q  <= nxt_addr_d;
            data_q  <= nxt_pat_d;
            wr_q    <= 1'b1;
            state_q <= S_WR_ISSUE;
          end
        end
        S_RD_ISSUE: begin
          rd_q    <= 1'b0;
          wcnt_q  <= '0;
          state_q <= S_RD_WAIT_LO;
        end
        S_RD_WAIT_LO: if (wait_met) begin
          wcnt_q  <= '0;
          state_q <= S_RD_WAIT_HI;
        end
        S_RD_WAIT_HI: if (wait_met) begin
          if (p0_q != cur_pat) begin
            if (err_q != '1) err_q <= err_q + ERR_WIDTH'(1);
            if (err_q == '0) begin
              fea_q <= addr_q;
              fee_q <= cur_pat;
              feg_q <= p0_q;
            end
          end
          if (last) begin
            be_q    <= '0;
            state_q <= S_FINISH;
          end else begin
            idx_q   <= nxt_idx_d;
            lfsr_q  <= nxt_lfsr_d;
            addr_q  <= nxt_addr_d;
            rd_q    <= 1'b1;
            state_q <= S_RD_ISSUE;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0) && !to_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // Wait-state watchdog: count unmet cycles, abort the run when the budget runs out.
      if (wait_st && !wait_met) begin
        if (to_hit) begin
          to_q    <= 1'b1;
          wr_q    <= 1'b0;
          rd_q    <= 1'b0;
          be_q    <= '0;
          state_q <= S_FINISH;
        end else begin
          wcnt_q  <= wcnt_q + WCNT_W'(1);
        end
      end
    end
  end

  assign p0_addr        = addr_q;
  assign p0_data        = data_q;
  assign p0_byte_en     = be_q;
  assign p0_wr_req      = wr_q;
  assign p0_rd_req      = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = to_q;
  assign error_count    = err_q;
  assign first_err_addr = fea_q;
  assign first_err_exp  = fee_q;
  assign first_err_got  = feg_q;

endmodule
